core_run_ctrl: RTL and testbench

- Run-control sequencer for single_cycle_core.
- Loads a program into instruction memory through a word-stream interface.
- Holds the core in reset during load, then releases it into a halted state.
- Gates core execution with a per-cycle enable for run, halt, single-step, EBREAK stop and one address breakpoint. The enable drives the top-level clock-gate cell of the core.

---
 rtl/core_run_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: streams a program into imem, then gates the core with run/halt/step/break control.
// Latency: imem write is combinational with the load handshake; all state changes take effect on the next edge.
// Backpressure: cmd_ready/ld_ready are combinational from state (and cmd_op in RUN); ld_valid stalls are absorbed freely.
module core_run_ctrl #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_arg,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       core_pc,
    input  logic [31:0]       core_instr,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    output logic              core_rst,
    output logic              core_en,
    output logic              halted,
    output logic              cmd_err,
    output logic [31:0]       cycle_count
);

    // One extra bit so a full-depth word count (IMEM_DEPTH == 2^ADDR_W) is representable.
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [31:0]       DEPTH32   = 32'(IMEM_DEPTH);
    localparam logic [31:0]       EBREAK    = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_HALTED,
        S_RUN,
        S_STEP
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_HALT = 2'b10,
        OP_STEP = 2'b11
    } op_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // next imem word address during LOAD
    logic [CNT_W-1:0]   last_q, last_d;     // index of the final word (N-1)
    logic [HOLD_W-1:0]  hold_q, hold_d;     // cycles already spent in RELEASE
    logic               first_q, first_d;   // first RUN cycle after HALTED
    logic               err_q, err_d;
    logic [31:0]        cyc_q, cyc_d;

    logic               cmd_acc;
    logic               load_req;
    logic               load_bad;
    logic               hit;
    logic               cyc_clr;

    // A LOAD is only ever accepted in IDLE/HALTED because cmd_ready in RUN is restricted to HALT.
    assign cmd_acc  = cmd_valid & cmd_ready;
    assign load_req = cmd_acc & (op_e'(cmd_op) == OP_LOAD);
    assign load_bad = (cmd_arg == 32'd0) || (cmd_arg > DEPTH32);

    // Stop condition: EBREAK fetched, or the armed breakpoint PC reached.
    assign hit = (core_instr == EBREAK) | (bp_en & (core_pc == bp_addr));

    assign imem_wdata  = ld_data;
    assign cmd_err     = err_q;
    assign cycle_count = cyc_q;

    // Next-state and per-cycle control outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        hold_d    = hold_q;
        first_d   = first_q;
        err_d     = 1'b0;
        cyc_clr   = 1'b0;
        cmd_ready = 1'b0;
        ld_ready  = 1'b0;
        imem_we   = 1'b0;
        imem_addr = '0;
        core_rst  = 1'b0;
        core_en   = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // RUN/STEP/HALT are accepted here but have nothing to act on.
                cmd_ready = 1'b1;
                core_rst  = 1'b1;
            end

            S_LOAD: begin
                core_rst  = 1'b1;
                ld_ready  = 1'b1;
                imem_addr = cnt_q[ADDR_W-1:0];
                if (ld_valid) begin
                    imem_we = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == last_q) begin
                        state_d = S_RELEASE;
                        hold_d  = '0;
                    end
                end
            end

            S_RELEASE: begin
                // Core reset stays asserted for exactly RESET_HOLD cycles so its PC lands at 0.
                core_rst = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_HALTED;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            S_HALTED: begin
                cmd_ready = 1'b1;
                halted    = 1'b1;
                if (cmd_acc) begin
                    unique case (op_e'(cmd_op))
                        OP_RUN: begin
                            state_d = S_RUN;
                            first_d = 1'b1;
                        end
                        OP_STEP: state_d = S_STEP;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                cmd_ready = (op_e'(cmd_op) == OP_HALT);
                first_d   = 1'b0;
                // The first cycle ignores a hit so execution can resume past the stop point.
                if (hit && !first_q) begin
                    state_d = S_HALTED;
                end else begin
                    core_en = 1'b1;
                    if (cmd_acc) begin
                        state_d = S_HALTED;
                    end
                end
            end

            S_STEP: begin
                core_en = 1'b1;
                state_d = S_HALTED;
            end

            default: begin
                state_d  = S_IDLE;
                core_rst = 1'b1;
            end
        endcase

        // LOAD handling shared by IDLE and HALTED.
        if (load_req) begin
            if (load_bad) begin
                err_d = 1'b1;
            end else begin
                state_d = S_LOAD;
                cnt_d   = '0;
                last_d  = cmd_arg[CNT_W-1:0] - CNT_ONE;
                cyc_clr = 1'b1;
            end
        end
    end

    // Saturating count of enabled core cycles, cleared by a successful LOAD.
    always_comb begin
        cyc_d = cyc_q;
        if (cyc_clr) begin
            cyc_d = '0;
        end else if (core_en && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            hold_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a tiny imem/PC model driven by the DUT outputs.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns after the edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_core_run_ctrl;

    localparam logic [1:0]  OP_LOAD = 2'b00;
    localparam logic [1:0]  OP_RUN  = 2'b01;
    localparam logic [1:0]  OP_HALT = 2'b10;
    localparam logic [1:0]  OP_STEP = 2'b11;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] EBRK    = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] core_pc;
    logic [31:0] core_instr;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        core_rst;
    logic        core_en;
    logic        halted;
    logic        cmd_err;
    logic [31:0] cycle_count;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    logic [31:0] mem [0:255];
    logic [31:0] pc = 32'd0;
    logic [31:0] words [0:15];

    always #5 clk = ~clk;

    core_run_ctrl #(.IMEM_DEPTH(256), .ADDR_W(8), .RESET_HOLD(4)) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_pc(core_pc), .core_instr(core_instr), .bp_en(bp_en), .bp_addr(bp_addr),
        .core_rst(core_rst), .core_en(core_en), .halted(halted), .cmd_err(cmd_err),
        .cycle_count(cycle_count)
    );

    // Instruction memory model written by the DUT.
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // Core PC model: reset to 0 while held, advance one word per enabled cycle.
    always @(posedge clk) begin
        if (core_rst) pc <= 32'd0;
        else if (core_en) pc <= pc + 32'd4;
    end

    assign core_pc    = pc;
    assign core_instr = mem[pc[9:2]];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] arg, input string nm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        #1;
        chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // LOAD n words from words[], optionally stalling ld_valid before word stall_at.
    task automatic do_load(input int n, input int stall_at, input int stall_cyc, input string nm);
        int rel;
        issue(OP_LOAD, n, {nm, "_cmd"});
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    ld_valid = 1'b0;
                    #1;
                    chk($sformatf("%s_stall%0d_we", nm, s), {31'd0, imem_we}, 32'd0);
                    chk($sformatf("%s_stall%0d_rdy", nm, s), {31'd0, ld_ready}, 32'd1);
                    tick();
                end
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            #1;
            chk($sformatf("%s_w%0d_we", nm, i), {31'd0, imem_we}, 32'd1);
            chk($sformatf("%s_w%0d_addr", nm, i), {24'd0, imem_addr}, i);
            chk($sformatf("%s_w%0d_data", nm, i), imem_wdata, words[i]);
            chk($sformatf("%s_w%0d_rst", nm, i), {31'd0, core_rst}, 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        rel = 0;
        for (int k = 0; k < 20; k++) begin
            if (halted === 1'b1) break;
            if (core_rst === 1'b1) rel++;
            tick();
        end
        chk({nm, "_release_cycles"}, rel, 32'd4);
        chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
        chk({nm, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        chk({nm, "_core_en"}, {31'd0, core_en}, 32'd0);
        chk({nm, "_cycles"}, cycle_count, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   n_en;
        int   we_before;

        tbl[0] = '{OP_RUN,  32'd5,          1'b0};
        tbl[1] = '{OP_STEP, 32'd0,          1'b0};
        tbl[2] = '{OP_HALT, 32'd0,          1'b0};
        tbl[3] = '{OP_LOAD, 32'd0,          1'b1};
        tbl[4] = '{OP_LOAD, 32'd257,        1'b1};
        tbl[5] = '{OP_LOAD, 32'hFFFF_FFFF,  1'b1};

        for (int i = 0; i < 256; i++) mem[i] = NOP;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 32'd0;
        ld_valid = 1'b0; ld_data = 32'd0; bp_en = 1'b0; bp_addr = 32'd0;
        tick(); tick();

        // Reset state.
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_core_en", {31'd0, core_en}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        rst_n = 1'b1;
        tick();

        // Commands in IDLE: non-LOAD ops do nothing, bad LOADs pulse cmd_err once.
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_op = tbl[i].op; cmd_arg = tbl[i].arg;
            #1;
            chk($sformatf("tbl%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
            tick();
            cmd_valid = 1'b0;
            #1;
            chk($sformatf("tbl%0d_err", i), {31'd0, cmd_err}, {31'd0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_idle_rst", i), {31'd0, core_rst}, 32'd1);
            chk($sformatf("tbl%0d_idle_ldrdy", i), {31'd0, ld_ready}, 32'd0);
            chk($sformatf("tbl%0d_halted", i), {31'd0, halted}, 32'd0);
            tick();
            chk($sformatf("tbl%0d_err_clr", i), {31'd0, cmd_err}, 32'd0);
        end
        chk("tbl_no_writes", we_cnt, 32'd0);

        // LOAD of three words with a two-cycle stall before the third.
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        do_load(3, 2, 2, "ld3");
        chk("ld3_mem0", mem[0], 32'hAAAA_0001);
        chk("ld3_mem1", mem[1], 32'hBBBB_0002);
        chk("ld3_mem2", mem[2], 32'hCCCC_0003);
        chk("ld3_we_cnt", we_cnt, 32'd3);

        // Reload from HALTED: straight-line NOPs with EBREAK at 0x20.
        for (int i = 0; i < 12; i++) words[i] = (i == 8) ? EBRK : NOP;
        do_load(12, -1, 0, "prog");

        // RUN into a breakpoint at 0x10.
        bp_en = 1'b1; bp_addr = 32'h10;
        issue(OP_RUN, 32'd0, "run_bp");
        n_en = 0;
        for (int k = 0; k < 40; k++) begin
            if (halted === 1'b1) break;
            if (core_en === 1'b1) n_en++;
            tick();
        end
        chk("bp_en_cycles", n_en, 32'd4);
        chk("bp_pc", core_pc, 32'h10);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_cycles", cycle_count, 32'd4);

        // STEP executes the breakpointed instruction.
        issue(OP_STEP, 32'd0, "step");
        chk("step_en", {31'd0, core_en}, 32'd1);
        chk("step_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("step_halted", {31'd0, halted}, 32'd1);
        chk("step_cycles", cycle_count, 32'd5);
        chk("step_pc", core_pc, 32'h14);

        // RUN onward; HALT asserted in the EBREAK cycle must not let it execute.
        issue(OP_RUN, 32'd0, "run_eb");
        cmd_valid = 1'b1; cmd_op = OP_RUN;
        #1;
        chk("run_ready_nonhalt", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (core_instr === EBRK || halted === 1'b1) break;
            tick();
        end
        cmd_valid = 1'b1; cmd_op = OP_HALT;
        #1;
        chk("eb_pc", core_pc, 32'h20);
        chk("eb_ready", {31'd0, cmd_ready}, 32'd1);
        chk("eb_en", {31'd0, core_en}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("eb_halted", {31'd0, halted}, 32'd1);
        chk("eb_cycles", cycle_count, 32'd8);

        // Resume past EBREAK, then a plain HALT: that cycle still executes.
        issue(OP_RUN, 32'd0, "resume");
        chk("resume_first_en", {31'd0, core_en}, 32'd1);
        tick();
        cmd_valid = 1'b1; cmd_op = OP_HALT;
        #1;
        chk("halt_en", {31'd0, core_en}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_cycles", cycle_count, 32'd10);
        chk("halt_pc", core_pc, 32'h28);

        // Reset asserted mid-LOAD after two of four words.
        issue(OP_LOAD, 32'd4, "mid_cmd");
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 32'hDEAD_0000 + i;
            tick();
        end
        we_before = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_core_rst", {31'd0, core_rst}, 32'd1);
        chk("mid_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("mid_imem_we", {31'd0, imem_we}, 32'd0);
        chk("mid_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("mid_halted", {31'd0, halted}, 32'd0);
        chk("mid_cycles", cycle_count, 32'd0);
        tick();
        chk("mid_no_write", we_cnt, we_before);
        ld_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) words[i] = 32'h1234_0000 + i;
        do_load(4, -1, 0, "reload");
        chk("reload_mem3", mem[3], 32'h1234_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
